// File: rtl/mult16_rr_scheduler_pkg.sv
// Shared widths, defaults and payload types for the round-robin multiplier scheduler.
// Contents:
//   MULT_W / PROD_W  operand and product widths of the shared multiplier
//   DEF_NREQ/IDW/CNTW default requester count, index width and counter width
//   operand_t        packed {a, b} operand pair carried through stage 1
package mult16_rr_scheduler_pkg;

  localparam int unsigned MULT_W   = 16;
  localparam int unsigned PROD_W   = 32;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_IDW  = 2;
  localparam int unsigned DEF_CNTW = 16;

  typedef struct packed {
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/mult16_rr_scheduler_mult.sv
// Existing combinational 16x16 unsigned multiplier shared by the scheduler.
// Ports:
//   product  out  32  a * b, unsigned
//   a        in   16  operand A
//   b        in   16  operand B
module multiplier_16bits_version11
  import mult16_rr_scheduler_pkg::*;
(
  output logic [PROD_W-1:0] product,
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b
);

  // Zero-extend both operands so the full 32-bit product is kept.
  assign product = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult16_rr_scheduler.sv
// Round-robin scheduler sharing one 16x16 multiplier among NREQ requesters.
// One operand pair is admitted per cycle into stage 1 (operand register); the
// multiplier sits between stage 1 and the result register that drives rsp_*.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_ready    per-requester accept (one-hot or zero)
//   req_a/req_b  packed operands, requester i at [16*i +: 16]
//   rsp_valid    product valid, held under back-pressure
//   rsp_ready    response consumer ready
//   rsp_prod     32-bit unsigned product
//   rsp_id       originating requester index
//   busy         any pair in flight
//   done_cnt     completed responses, wrapping counter
module mult16_rr_scheduler
  import mult16_rr_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = DEF_IDW,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MULT_W-1:0] req_a,
  input  logic [NREQ*MULT_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PROD_W-1:0]      rsp_prod,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy,
  output logic [CNTW-1:0]        done_cnt
);

  // Round-robin pick: rotate so ptr sits at bit 0, take the lowest set bit,
  // rotate the offset back. Wraps use explicit compares so any NREQ works.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  base);
    logic [NREQ-1:0] rot;
    logic [IDW:0]    idx;
    logic [IDW-1:0]  off;
    logic            found;
    rot   = '0;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (IDW+1)'(base) + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      rot[k] = vld[idx[IDW-1:0]];
    end
    // Descending scan so the lowest rotated position wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    idx = (IDW+1)'(base) + (IDW+1)'(off);
    if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
    return {found, idx[IDW-1:0]};
  endfunction

  logic             s1_valid;
  operand_t         s1_op;
  logic [IDW-1:0]   s1_id;
  logic [IDW-1:0]   ptr;
  logic             adv1;
  logic             adv2;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             xfer;
  operand_t         gnt_op;
  logic [IDW-1:0]   ptr_next;
  logic [PROD_W-1:0] mult_prod;

  // Pipeline advance, arbitration and operand selection.
  always_comb begin
    adv2 = !rsp_valid || rsp_ready;
    adv1 = !s1_valid || adv2;
    {gnt_found, gnt_idx} = rr_pick(req_valid, ptr);
    xfer = adv1 && gnt_found;
    req_ready = '0;
    // rst_n gate keeps req_ready at 0 while reset is held.
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && xfer && (gnt_idx == IDW'(i))) req_ready[i] = 1'b1;
    end
    gnt_op.a = req_a[int'(gnt_idx)*MULT_W +: MULT_W];
    gnt_op.b = req_b[int'(gnt_idx)*MULT_W +: MULT_W];
    ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_idx + IDW'(1));
  end

  assign busy = s1_valid || rsp_valid;

  multiplier_16bits_version11 u_mult (
    .product (mult_prod),
    .a       (s1_op.a),
    .b       (s1_op.b)
  );

  // Stage 1 operand register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_op    <= gnt_op;
      s1_id    <= gnt_idx;
      ptr      <= ptr_next;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register; frozen while the consumer stalls a valid response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_prod <= mult_prod;
        rsp_id   <= s1_id;
      end
    end
  end

  // Completed-response counter, wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_cnt <= done_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mult16_rr_scheduler.sv
// Self-checking bench for mult16_rr_scheduler. A queue-based model tracks the
// pairs in flight (head visible one edge after acceptance, at most two held)
// and a round-robin pointer computed with modular arithmetic.
module tb_mult16_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*16-1:0]   req_a;
  logic [NREQ*16-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_prod;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;
  logic [CNTW-1:0]      done_cnt;

  logic [15:0] ta  [NREQ];
  logic [15:0] tbv [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[16*gi +: 16] = ta[gi];
    assign req_b[16*gi +: 16] = tbv[gi];
  end

  mult16_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    bit          fresh;
  } item_t;

  item_t       q[$];
  int          mptr;
  int          nresp;
  int          last_acc;
  logic [15:0] mcnt;
  int          checks;
  int          errors;

  function automatic bit m_rsp_valid();
    return (q.size() > 0) && !q[0].fresh;
  endfunction

  function automatic int model_grant();
    int taken;
    taken = (m_rsp_valid() && rsp_ready) ? 1 : 0;
    if (q.size() - taken >= 2) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [55:0] exp_vec();
    int              g;
    logic [NREQ-1:0] r;
    logic [31:0]     p;
    g = model_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    if (m_rsp_valid()) begin
      p = 32'(q[0].a) * 32'(q[0].b);
      return {r, 1'b1, 1'b1, mcnt, p, IDW'(q[0].id)};
    end
    return {r, 1'b0, (q.size() > 0), mcnt, 32'd0, 2'd0};
  endfunction

  function automatic logic [55:0] obs_vec();
    return {req_ready, rsp_valid, busy, done_cnt,
            (rsp_valid ? rsp_prod : 32'd0), (rsp_valid ? rsp_id : 2'd0)};
  endfunction

  // Advance DUT and model by one clock edge using the currently driven inputs.
  task automatic tick();
    int    g;
    bit    taken;
    item_t it;
    g     = model_grant();
    taken = m_rsp_valid() && rsp_ready;
    @(posedge clk);
    if (taken) begin
      q.delete(0);
      mcnt++;
      nresp++;
    end
    for (int i = 0; i < q.size(); i++) q[i].fresh = 1'b0;
    if (g >= 0) begin
      it.a = ta[g]; it.b = tbv[g]; it.id = g; it.fresh = 1'b1;
      q.push_back(it);
      mptr = (g + 1) % NREQ;
    end
    last_acc = g;
    #1;
  endtask

  task automatic new_ops(input int i);
    int r;
    r = $urandom_range(0, 7);
    ta[i]  = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
    r = $urandom_range(0, 7);
    tbv[i] = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
  endtask

  task automatic model_reset();
    q.delete();
    mptr  = 0;
    mcnt  = '0;
    nresp = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({req_ready, rsp_valid, busy, done_cnt, rsp_prod, rsp_id} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, rsp_valid, busy, done_cnt, rsp_prod, rsp_id});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    ta[2] = 16'hFFFF; tbv[2] = 16'hFFFF;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL single_s1: got %h expected %h", obs_vec(), exp_vec());
    end
    tick();
    #1;
    checks++;
    if (!(rsp_valid === 1'b1 && rsp_prod === 32'hFFFE0001 && rsp_id === 2'd2)) begin
      errors++;
      $display("FAIL single_rsp: got v=%b prod=%h id=%0d expected v=1 prod=fffe0001 id=2",
               rsp_valid, rsp_prod, rsp_id);
    end
    tick();
    #1;
    checks++;
    if (done_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got cnt=%0d busy=%b expected cnt=1 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_rr_order();
    logic [NREQ-1:0] want;
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = 4'(1 << (k % 4));
      checks++;
      if (req_ready !== want) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rr_cycle%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) new_ops(last_acc);
    end
    req_valid = '0;
    repeat (2) tick();
    #1;
    checks++;
    if (done_cnt !== 16'd8) begin
      errors++; $display("FAIL rr_done_cnt: got %0d expected 8", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int nacc;
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    rsp_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(req_ready & req_valid)) nacc++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_hold%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) new_ops(last_acc);
    end
    #1;
    checks++;
    if (nacc !== 2 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_accepts: got %0d ready=%b expected 2 ready=0000", nacc, req_ready);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_drain%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt !== 16'd6) begin
      errors++; $display("FAIL bp_final: got busy=%b cnt=%0d expected busy=0 cnt=6", busy, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_bubble%0d: got rsp_valid=%b expected 1", c, rsp_valid);
        end
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) new_ops(last_acc);
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          new_ops(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_drain%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt !== mcnt) begin
      errors++; $display("FAIL rand_final: got busy=%b cnt=%0d expected busy=0 cnt=%0d", busy, done_cnt, mcnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmid_fill%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (obs_vec() !== exp_vec() || busy !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_full: got %h expected %h", obs_vec(), exp_vec());
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, done_cnt, rsp_prod, rsp_id} !== 56'd0) begin
      errors++;
      $display("FAIL rmid_zero: got %h expected 0",
               {req_ready, rsp_valid, busy, done_cnt, rsp_prod, rsp_id});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_first_grant: got %b expected 0001", req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmid_after%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req_valid = '1;
    rsp_ready = 1'b1;
    cyc = 0;
    while (nresp < 65535 && cyc < 70000) begin
      tick();
      if (last_acc >= 0) new_ops(last_acc);
      cyc++;
    end
    #1;
    checks++;
    if (nresp != 65535 || done_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre: got cnt=%0d after %0d cycles expected 65535", done_cnt, cyc);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_cycle: got %h expected %h", obs_vec(), exp_vec());
    end
    tick();
    #1;
    checks++;
    if (done_cnt !== 16'h0000 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: got cnt=%0d v=%b expected cnt=0 v=1", done_cnt, rsp_valid);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_acc  = -1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ta[i]  = '0;
      tbv[i] = '0;
    end
    model_reset();
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
